// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU sequencer: opcode encoding, ALU select codes and FSM states.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_MUL  = 4'd3,
        OP_HALF = 4'd4,
        OP_MOV  = 4'd5,
        OP_LDI  = 4'd6,
        OP_OUT  = 4'd7
    } opcode_e;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_MUL  = 3'b011;
    localparam logic [2:0] ALU_HALF = 3'b100;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_e;

    // Opcodes whose retirement writes the ALU result and updates the flags.
    function automatic logic updates_flags(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_HALF, OP_MOV: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction stream, ALU operand/result buses, output stream and flags of the ALU sequencer.
interface alu_sequencer_if #(
    parameter int WIDTH  = 8,
    parameter int N_REGS = 4
);
    localparam int RW = $clog2(N_REGS);
    localparam int IW = 4 + 2 * RW + WIDTH;

    logic [IW-1:0]    instr;
    logic             instr_valid;
    logic             instr_ready;
    logic [WIDTH-1:0] bus_a;
    logic [WIDTH-1:0] bus_b;
    logic [2:0]       alu_sel;
    logic [WIDTH-1:0] alu_out;
    logic             zero;
    logic             negative;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             zero_flag;
    logic             neg_flag;
    logic             illegal;

    modport master (
        input  instr, instr_valid, alu_out, zero, negative, out_ready,
        output instr_ready, bus_a, bus_b, alu_sel, out_data, out_valid,
               zero_flag, neg_flag, illegal
    );

    modport slave (
        output instr, instr_valid, alu_out, zero, negative, out_ready,
        input  instr_ready, bus_a, bus_b, alu_sel, out_data, out_valid,
               zero_flag, neg_flag, illegal
    );

endinterface

// File: rtl/alu_regfile.sv
// Register file: N_REGS x WIDTH, two asynchronous read ports, one synchronous write port.
module alu_regfile #(
    parameter int WIDTH  = 8,
    parameter int N_REGS = 4,
    parameter int RW     = $clog2(N_REGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic [RW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [RW-1:0]    i_raddr_a,
    output logic [WIDTH-1:0] o_rdata_a,
    input  logic [RW-1:0]    i_raddr_b,
    output logic [WIDTH-1:0] o_rdata_b
);

    logic [WIDTH-1:0] r_regs [N_REGS];

    // Storage with asynchronous clear and single write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_regs[i_raddr_a];
    assign o_rdata_b = r_regs[i_raddr_b];

endmodule

// File: rtl/alu_sequencer.sv
// Two-state sequencer that fetches operands, drives an external ALU and writes results back.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int N_REGS = 4
) (
    input logic             clk,
    input logic             rst,
    alu_sequencer_if.master bus
);

    localparam int RW = $clog2(N_REGS);
    localparam int IW = 4 + 2 * RW + WIDTH;

    state_e           r_state;
    state_e           w_state_next;
    logic [3:0]       r_opcode;
    logic [RW-1:0]    r_rd;
    logic [WIDTH-1:0] r_imm;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [2:0]       r_sel;
    logic [WIDTH-1:0] r_out_data;
    logic             r_zero_flag;
    logic             r_neg_flag;

    logic [3:0]       w_opcode;
    logic [RW-1:0]    w_rd;
    logic [RW-1:0]    w_rs;
    logic [WIDTH-1:0] w_imm;
    logic [WIDTH-1:0] w_rdata_a;
    logic [WIDTH-1:0] w_rdata_b;
    logic [WIDTH-1:0] w_op_a_next;
    logic [WIDTH-1:0] w_op_b_next;
    logic [2:0]       w_sel_next;
    logic             w_accept;
    logic             w_retire;
    logic             w_we;
    logic [WIDTH-1:0] w_wdata;

    assign w_opcode = bus.instr[IW-1 -: 4];
    assign w_rd     = bus.instr[2*RW+WIDTH-1 -: RW];
    assign w_rs     = bus.instr[RW+WIDTH-1 -: RW];
    assign w_imm    = bus.instr[WIDTH-1:0];

    // Port A reads the destination, port B the source register of the incoming instruction.
    alu_regfile #(.WIDTH(WIDTH), .N_REGS(N_REGS), .RW(RW)) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .i_we      (w_we),
        .i_waddr   (r_rd),
        .i_wdata   (w_wdata),
        .i_raddr_a (w_rd),
        .o_rdata_a (w_rdata_a),
        .i_raddr_b (w_rs),
        .o_rdata_b (w_rdata_b)
    );

    assign w_accept = (r_state == IDLE) && bus.instr_valid;
    assign w_retire = (r_state == EXEC) && ((r_opcode != OP_OUT) || bus.out_ready);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; OUT holds EXEC until the downstream handshake completes.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.instr_valid) begin
                    w_state_next = EXEC;
                end else begin
                    w_state_next = IDLE;
                end
            end
            EXEC: begin
                if (w_retire) begin
                    w_state_next = IDLE;
                end else begin
                    w_state_next = EXEC;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Operand and select values presented to the ALU for each opcode.
    always_comb begin
        w_op_a_next = '0;
        w_op_b_next = '0;
        w_sel_next  = ALU_PASS;
        case (w_opcode)
            OP_ADD: begin
                w_op_a_next = w_rdata_a;
                w_op_b_next = w_rdata_b;
                w_sel_next  = ALU_ADD;
            end
            OP_SUB: begin
                w_op_a_next = w_rdata_a;
                w_op_b_next = w_rdata_b;
                w_sel_next  = ALU_SUB;
            end
            OP_MUL: begin
                w_op_a_next = w_rdata_a;
                w_op_b_next = w_rdata_b;
                w_sel_next  = ALU_MUL;
            end
            OP_HALF: begin
                w_op_a_next = w_rdata_a;
                w_sel_next  = ALU_HALF;
            end
            OP_MOV, OP_OUT: begin
                w_op_a_next = w_rdata_b;
            end
            default: begin
                w_op_a_next = '0;
            end
        endcase
    end

    // Writeback selection at the retiring EXEC cycle.
    always_comb begin
        w_we    = 1'b0;
        w_wdata = bus.alu_out;
        if (r_opcode == OP_LDI) begin
            w_we    = w_retire;
            w_wdata = r_imm;
        end else begin
            w_we    = w_retire && updates_flags(r_opcode);
            w_wdata = bus.alu_out;
        end
    end

    // Instruction latch and ALU operand registers; operands return to zero once retired.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_opcode   <= '0;
            r_rd       <= '0;
            r_imm      <= '0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_sel      <= ALU_PASS;
            r_out_data <= '0;
        end else if (w_accept) begin
            r_opcode <= w_opcode;
            r_rd     <= w_rd;
            r_imm    <= w_imm;
            r_op_a   <= w_op_a_next;
            r_op_b   <= w_op_b_next;
            r_sel    <= w_sel_next;
            if (w_opcode == OP_OUT) begin
                r_out_data <= w_rdata_b;
            end
        end else if (w_retire) begin
            r_op_a <= '0;
            r_op_b <= '0;
            r_sel  <= ALU_PASS;
        end
    end

    // Flags capture the ALU status only for result-producing opcodes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_zero_flag <= 1'b0;
            r_neg_flag  <= 1'b0;
        end else if (w_retire && updates_flags(r_opcode)) begin
            r_zero_flag <= bus.zero;
            r_neg_flag  <= bus.negative;
        end
    end

    assign bus.instr_ready = (r_state == IDLE) && !rst;
    assign bus.bus_a       = r_op_a;
    assign bus.bus_b       = r_op_b;
    assign bus.alu_sel     = r_sel;
    assign bus.out_data    = r_out_data;
    assign bus.out_valid   = (r_state == EXEC) && (r_opcode == OP_OUT);
    assign bus.illegal     = (r_state == EXEC) && r_opcode[3];
    assign bus.zero_flag   = r_zero_flag;
    assign bus.neg_flag    = r_neg_flag;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU, a vector table and multi-cycle sequences.
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_pass  = 0;
    int   n_total = 0;

    alu_sequencer_if #(.WIDTH(8), .N_REGS(4)) sif ();
    alu_sequencer #(.WIDTH(8), .N_REGS(4)) dut (.clk(clk), .rst(rst), .bus(sif));

    always #5 clk = ~clk;

    logic signed [7:0] alu_a, alu_b, alu_r;

    // Reference combinational ALU.
    always_comb begin
        alu_a = $signed(sif.bus_a);
        alu_b = $signed(sif.bus_b);
        case (sif.alu_sel)
            3'b000:  alu_r = alu_a;
            3'b001:  alu_r = alu_a + alu_b;
            3'b010:  alu_r = alu_a - alu_b;
            3'b011:  alu_r = alu_a * alu_b;
            3'b100:  alu_r = alu_a / 8'sd2;
            default: alu_r = 8'sd0;
        endcase
    end
    assign sif.alu_out  = alu_r;
    assign sif.zero     = (alu_r == 8'sd0);
    assign sif.negative = alu_r[7];

    typedef struct {
        logic [3:0] op;
        logic [1:0] rd;
        logic [1:0] rs;
        logic [7:0] imm;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
        logic [2:0] exp_sel;
        logic       exp_ov;
        logic [7:0] exp_od;
        logic       exp_ill;
        logic       exp_z;
        logic       exp_n;
    } vec_t;

    vec_t vecs[$];

    logic [7:0] s_a, s_b, s_od;
    logic [2:0] s_sel;
    logic       s_ov, s_ill, s_rdy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (sif.instr_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            n_total++;
            $display("FAIL accept_timeout: instr_ready still %b after %0d cycles", sif.instr_ready, n);
        end
    endtask

    // Issue one instruction with out_ready high; sample EXEC-cycle outputs, return in IDLE at a negedge.
    task automatic issue(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                         input logic [7:0] imm);
        sif.instr       = {op, rd, rs, imm};
        sif.instr_valid = 1'b1;
        wait_ready();
        @(posedge clk);
        #1;
        sif.instr_valid = 1'b0;
        @(negedge clk);
        s_a   = sif.bus_a;
        s_b   = sif.bus_b;
        s_sel = sif.alu_sel;
        s_ov  = sif.out_valid;
        s_od  = sif.out_data;
        s_ill = sif.illegal;
        s_rdy = sif.instr_ready;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        sif.instr       = '0;
        sif.instr_valid = 1'b0;
        sif.out_ready   = 1'b1;

        //           op       rd    rs    imm     a      b      sel    ov    od     ill   z     n
        vecs.push_back('{OP_LDI,  2'd0, 2'd0, 8'h05, 8'h00, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{OP_LDI,  2'd1, 2'd0, 8'h03, 8'h00, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{OP_ADD,  2'd0, 2'd1, 8'h00, 8'h05, 8'h03, 3'd1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{OP_OUT,  2'd0, 2'd0, 8'h00, 8'h08, 8'h00, 3'd0, 1'b1, 8'h08, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{OP_LDI,  2'd0, 2'd0, 8'h03, 8'h00, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{OP_LDI,  2'd1, 2'd0, 8'h05, 8'h00, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{OP_SUB,  2'd0, 2'd1, 8'h00, 8'h03, 8'h05, 3'd2, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{OP_OUT,  2'd0, 2'd0, 8'h00, 8'hFE, 8'h00, 3'd0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{OP_LDI,  2'd2, 2'd0, 8'hFD, 8'h00, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{OP_HALF, 2'd2, 2'd0, 8'h00, 8'hFD, 8'h00, 3'd4, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{OP_OUT,  2'd0, 2'd2, 8'h00, 8'hFF, 8'h00, 3'd0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{OP_LDI,  2'd3, 2'd0, 8'h10, 8'h00, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{OP_MUL,  2'd3, 2'd3, 8'h00, 8'h10, 8'h10, 3'd3, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{OP_OUT,  2'd0, 2'd3, 8'h00, 8'h00, 8'h00, 3'd0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{OP_LDI,  2'd1, 2'd0, 8'h7F, 8'h00, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{OP_ADD,  2'd1, 2'd1, 8'h00, 8'h7F, 8'h7F, 3'd1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{OP_OUT,  2'd0, 2'd1, 8'h00, 8'hFE, 8'h00, 3'd0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{OP_MOV,  2'd2, 2'd0, 8'h00, 8'hFE, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{OP_OUT,  2'd0, 2'd2, 8'h00, 8'hFE, 8'h00, 3'd0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{OP_LDI,  2'd3, 2'd0, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{OP_NOP,  2'd1, 2'd2, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{4'd9,    2'd1, 2'd1, 8'h55, 8'h00, 8'h00, 3'd0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{OP_OUT,  2'd0, 2'd1, 8'h00, 8'hFE, 8'h00, 3'd0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{OP_OUT,  2'd0, 2'd3, 8'h00, 8'h00, 8'h00, 3'd0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{OP_MOV,  2'd0, 2'd3, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0});

        // Reset state
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_instr_ready", 32'(sif.instr_ready), 32'd0);
        check("rst_out_valid",   32'(sif.out_valid),   32'd0);
        check("rst_illegal",     32'(sif.illegal),     32'd0);
        check("rst_bus_a",       32'(sif.bus_a),       32'd0);
        check("rst_bus_b",       32'(sif.bus_b),       32'd0);
        check("rst_alu_sel",     32'(sif.alu_sel),     32'd0);
        check("rst_out_data",    32'(sif.out_data),    32'd0);
        check("rst_flags",       32'({sif.zero_flag, sif.neg_flag}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(sif.instr_ready), 32'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            issue(vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].imm);
            check($sformatf("v%0d_bus_a", i),   32'(s_a),   32'(vecs[i].exp_a));
            check($sformatf("v%0d_bus_b", i),   32'(s_b),   32'(vecs[i].exp_b));
            check($sformatf("v%0d_alu_sel", i), 32'(s_sel), 32'(vecs[i].exp_sel));
            check($sformatf("v%0d_out_valid", i), 32'(s_ov), 32'(vecs[i].exp_ov));
            if (vecs[i].exp_ov) check($sformatf("v%0d_out_data", i), 32'(s_od), 32'(vecs[i].exp_od));
            check($sformatf("v%0d_illegal", i), 32'(s_ill), 32'(vecs[i].exp_ill));
            check($sformatf("v%0d_busy", i),    32'(s_rdy), 32'd0);
            check($sformatf("v%0d_zero_flag", i), 32'(sif.zero_flag), 32'(vecs[i].exp_z));
            check($sformatf("v%0d_neg_flag", i),  32'(sif.neg_flag),  32'(vecs[i].exp_n));
            check($sformatf("v%0d_idle_illegal", i), 32'(sif.illegal), 32'd0);
            check($sformatf("v%0d_idle_ready", i),   32'(sif.instr_ready), 32'd1);
        end

        // OUT R1 (0xFE) stalled by out_ready=0 for 5 cycles
        sif.out_ready   = 1'b0;
        sif.instr       = {OP_OUT, 2'd0, 2'd1, 8'h00};
        sif.instr_valid = 1'b1;
        wait_ready();
        @(posedge clk);
        #1;
        sif.instr_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("stall%0d_ready", c),     32'(sif.instr_ready), 32'd0);
            check($sformatf("stall%0d_out_valid", c), 32'(sif.out_valid),   32'd1);
            check($sformatf("stall%0d_out_data", c),  32'(sif.out_data),    32'hFE);
        end
        sif.out_ready = 1'b1;
        #1;
        check("stall_release_valid", 32'(sif.out_valid), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("stall_done_ready", 32'(sif.instr_ready), 32'd1);
        check("stall_done_valid", 32'(sif.out_valid),   32'd0);
        check("stall_done_bus_a", 32'(sif.bus_a),       32'd0);

        // Reset during EXEC of ADD R1,R1
        issue(OP_LDI, 2'd1, 2'd0, 8'h07);
        sif.instr       = {OP_ADD, 2'd1, 2'd1, 8'h00};
        sif.instr_valid = 1'b1;
        wait_ready();
        @(posedge clk);
        #1;
        sif.instr_valid = 1'b0;
        @(negedge clk);
        check("abort_exec_bus_a", 32'(sif.bus_a),   32'h07);
        check("abort_exec_sel",   32'(sif.alu_sel), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("abort_rst_ready", 32'(sif.instr_ready), 32'd0);
        check("abort_rst_bus_a", 32'(sif.bus_a),       32'd0);
        @(posedge clk);
        @(negedge clk);
        check("abort_rst_ready2", 32'(sif.instr_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("abort_release_ready", 32'(sif.instr_ready), 32'd1);
        check("abort_flags", 32'({sif.zero_flag, sif.neg_flag}), 32'd0);
        for (int r = 0; r < 4; r++) begin
            issue(OP_OUT, 2'd0, 2'(r), 8'h00);
            check($sformatf("abort_R%0d", r), 32'(s_od), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
